// File: rtl/cluster_truncator_nway.sv
// Cluster truncator: latches a vpf bus and, on each free-running edge, strips up to
// NREMOVE least-significant 1s from the lowest non-zero segment of the working copy.
module cluster_truncator_nway #(
   parameter int MXVPF    = 1536,
   parameter int MXSEGS   = 16,
   parameter int NREMOVE  = 2,
   parameter int PASSBITS = 3
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic                latch_pulse,
   input  logic                freeze,
   input  logic [MXVPF-1:0]    vpfs_in,
   output logic [MXVPF-1:0]    vpfs_out,
   output logic [PASSBITS-1:0] pass,
   output logic                empty,
   output logic                overflow,
   output logic [7:0]          overflow_cnt
);

   localparam int SEGSIZE = MXVPF / MXSEGS;
   localparam logic [SEGSIZE-1:0]  SEG_ONE  = {{(SEGSIZE-1){1'b0}}, 1'b1};
   localparam logic [PASSBITS-1:0] PASS_ONE = {{(PASSBITS-1){1'b0}}, 1'b1};

   // Each step clears the lowest set bit; a zero segment stays zero.
   function automatic logic [SEGSIZE-1:0] strip_ones(input logic [SEGSIZE-1:0] a);
      logic [SEGSIZE-1:0] r;
      r = a;
      for (int i = 0; i < NREMOVE; i++) begin
         r = r & (r - SEG_ONE);
      end
      return r;
   endfunction

   logic [MXSEGS-1:0][SEGSIZE-1:0] seg_q, seg_d;
   logic [MXSEGS-1:0]              seg_nz;
   logic [PASSBITS-1:0]            pass_q, pass_d;
   logic                           ovf_q, ovf_d;
   logic [7:0]                     cnt_q, cnt_d;
   logic                           found;

   always_comb begin
      for (int k = 0; k < MXSEGS; k++) begin
         seg_nz[k] = |seg_q[k];
      end
   end

   assign empty    = ~|seg_nz;
   assign vpfs_out = seg_q;
   assign pass     = pass_q;
   assign overflow = ovf_q;
   assign overflow_cnt = cnt_q;

   // Segment selection looks only at registered contents, keeping carry chains per segment.
   always_comb begin
      seg_d = seg_q;
      found = 1'b0;
      if (latch_pulse) begin
         seg_d = vpfs_in;
      end else if (!freeze) begin
         for (int k = 0; k < MXSEGS; k++) begin
            if (!found && seg_nz[k]) begin
               seg_d[k] = strip_ones(seg_q[k]);
               found    = 1'b1;
            end
         end
      end
   end

   always_comb begin
      pass_d = pass_q;
      ovf_d  = 1'b0;
      cnt_d  = cnt_q;
      if (latch_pulse) begin
         pass_d = '0;
         ovf_d  = ~empty;
         if (!empty && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
         end
      end else if (!freeze) begin
         if (pass_q != {PASSBITS{1'b1}}) begin
            pass_d = pass_q + PASS_ONE;
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         seg_q  <= '0;
         pass_q <= '0;
         ovf_q  <= 1'b0;
         cnt_q  <= '0;
      end else begin
         seg_q  <= seg_d;
         pass_q <= pass_d;
         ovf_q  <= ovf_d;
         cnt_q  <= cnt_d;
      end
   end

endmodule
